// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: MIPS-style HI/LO multiply/divide unit.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a new operation (accepted only when idle)
//   op           0 mult, 1 multu, 2 div, 3 divu
//   src_a        RS operand (multiplicand / dividend), also mthi/mtlo data
//   src_b        RT operand (multiplier / divisor)
//   mthi, mtlo   write src_a into HI / LO when idle, not flushing, start low
//   flush        abort the in-flight operation (HI/LO untouched, no done)
//   busy         operation in flight
//   done         one-cycle pulse when HI/LO are committed
//   div_by_zero  one-cycle pulse together with done on a zero divisor
//   hi, lo       architectural HI/LO registers
//
// Configuration macro MULDIV_FAST_MULT_EN: when defined, MUL uses a single-cycle
// 64-bit multiplier; otherwise MUL runs a 32-cycle shift-add on magnitudes.
// Division is the same in both builds (32-cycle restoring radix-2).
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t               state;
    logic [WIDTH-1:0]     opa;      // |src_a| for signed ops, raw otherwise
    logic [WIDTH-1:0]     opb;      // |src_b| for signed ops, raw otherwise
    logic [1:0]           op_q;
    logic [2*WIDTH-1:0]   acc;      // mul: product/multiplier; div: {rem, quotient}
    logic [CW-1:0]        cnt;
    logic                 neg_q;    // negate product / quotient at FIX
    logic                 neg_r;    // negate remainder at FIX
    logic                 dz_q;

    // Operand signs and magnitudes (op[0]==0 selects the signed variants)
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;

    // Restoring division step
    logic [WIDTH:0]       partial, diff;
    logic [2*WIDTH-1:0]   div_next;

    // FIX-stage sign application
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     q_fix, r_fix;

    always_comb begin
        a_neg = ~op[0] & src_a[WIDTH-1];
        b_neg = ~op[0] & src_b[WIDTH-1];
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;

        // Shift next dividend bit into the remainder, subtract if it fits
        partial  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = partial - {1'b0, opb};
        div_next = diff[WIDTH] ? {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};

        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

`ifndef MULDIV_FAST_MULT_EN
    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole product right.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            opa         <= '0;
            opb         <= '0;
            op_q        <= '0;
            acc         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            opa   <= a_mag;
                            opb   <= b_mag;
                            op_q  <= op;
                            cnt   <= '0;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            busy  <= 1'b1;
                            dz_q  <= 1'b0;
                            if (op[1]) begin
                                acc <= {{WIDTH{1'b0}}, a_mag};
                                if (src_b == '0) begin
                                    dz_q  <= 1'b1;
                                    state <= FIX;
                                end else begin
                                    state <= DIV;
                                end
                            end else begin
                                acc   <= {{WIDTH{1'b0}}, b_mag};
                                state <= MUL;
                            end
                        end else begin
                            if (mthi) hi <= src_a;
                            if (mtlo) lo <= src_a;
                        end
                    end
                    MUL: begin
`ifdef MULDIV_FAST_MULT_EN
                        acc   <= {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
                        state <= FIX;
`else
                        acc <= mul_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= FIX;
`endif
                    end
                    DIV: begin
                        acc <= div_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= FIX;
                    end
                    FIX: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (dz_q) begin
                            div_by_zero <= 1'b1;
                        end else if (op_q[1]) begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        flush = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    logic mon_on = 1'b0;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo),
        .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: returns {div_by_zero, hi, lo}
    function automatic logic [64:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin p = 64'(sa * sb); return {1'b0, p}; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
            2'd2: begin
                if (b == 0) return {1'b1, 64'd0};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, 64'd0};
                return {1'b0, b32(a % b), b32(a / b)};
            end
        endcase
    endfunction

    function automatic logic [31:0] b32(input logic [31:0] x);
        return x;
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [31:0] b);
        if (o[1]) return (b == 0) ? 1 : 33;
        return MUL_LAT;
    endfunction

    // Transaction-level model: a pending result plus edges remaining to commit
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
    logic [64:0] m_res = '0;
    int          m_rem = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0;
            m_dz <= 1'b0; m_res <= '0; m_rem <= 0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_rem > 0) begin
                if (flush) begin
                    m_rem <= 0; m_busy <= 1'b0;
                end else if (m_rem == 1) begin
                    m_rem <= 0; m_busy <= 1'b0; m_done <= 1'b1;
                    if (m_res[64]) m_dz <= 1'b1;
                    else begin m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; end
                end else begin
                    m_rem <= m_rem - 1;
                end
            end else if (!flush) begin
                if (start) begin
                    m_res  <= model_res(op, src_a, src_b);
                    m_rem  <= latency(op, src_b);
                    m_busy <= 1'b1;
                end else begin
                    if (mthi) m_hi <= src_a;
                    if (mtlo) m_lo <= src_a;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (mon_on) begin
            check("mon_hi", {32'd0, hi}, {32'd0, m_hi});
            check("mon_lo", {32'd0, lo}, {32'd0, m_lo});
            check("mon_busy", {63'd0, busy}, {63'd0, m_busy});
            check("mon_done", {63'd0, done}, {63'd0, m_done});
            check("mon_dz", {63'd0, div_by_zero}, {63'd0, m_dz});
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic with_mtlo);
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1; mtlo = with_mtlo;
        @(posedge clk);
        #1;
        start = 1'b0; mtlo = 1'b0;
    endtask

    // Called at #1 after the accepting edge; edges counts edges after it
    task automatic wait_done(output int edges, output int bcyc);
        edges = 0;
        bcyc = busy ? 1 : 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) bcyc++;
        end
        check("done_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_edges, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
        int e, bc;
        issue(o, a, b, 1'b0);
        wait_done(e, bc);
        check({nm, "_done_edge"}, 64'(e + 1), 64'(exp_edges));
        check({nm, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({nm, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        check({nm, "_dz"}, {63'd0, div_by_zero}, {63'd0, exp_dz});
    endtask

    initial begin
        int e, bc, ndone;

        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_on = 1'b1;

        // Signed divide -7 / 2, with latency and busy duration
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done(e, bc);
        check("div_done_edge", 64'(e + 1), 64'd34);
        check("div_busy_cycles", 64'(bc), 64'd33);
        check("div_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        check("div_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);

        run_op("divu", 2'd3, 32'hFFFF_FFFF, 32'h10, 34, 32'hF, 32'h0FFF_FFFF, 1'b0);
        run_op("div0", 2'd2, 32'd5, 32'd0, 2, 32'hF, 32'h0FFF_FFFF, 1'b1);
        run_op("divovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 1'b0);
        run_op("mult", 2'd0, 32'hFFFF_FFFF, 32'd2, MUL_LAT + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'd2, MUL_LAT + 1, 32'h1, 32'hFFFF_FFFE, 1'b0);

        // Flush during the tenth DIV cycle, restart in the following idle cycle
        issue(2'd2, 32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_done", {63'd0, done}, 64'd0);
        check("flush_hi", {32'd0, hi}, 64'h1);
        check("flush_lo", {32'd0, lo}, 64'hFFFF_FFFE);
        op = 2'd3; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_busy", {63'd0, busy}, 64'd1);
        wait_done(e, bc);
        check("restart_lo", {32'd0, lo}, 64'd14);
        check("restart_hi", {32'd0, hi}, 64'd2);

        // mthi while busy is ignored
        issue(2'd1, 32'd3, 32'd4, 1'b0);
        @(negedge clk);
        mthi = 1'b1; src_a = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        wait_done(e, bc);
        check("mthi_busy_hi", {32'd0, hi}, 64'd0);
        check("mthi_busy_lo", {32'd0, lo}, 64'd12);
        // mthi while idle
        @(negedge clk);
        mthi = 1'b1; src_a = 32'h1234;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        check("mthi_idle_hi", {32'd0, hi}, 64'h1234);
        // start and mtlo together: start wins
        issue(2'd3, 32'h1234, 32'd2, 1'b1);
        check("mtlo_dropped", {32'd0, lo}, 64'd12);
        wait_done(e, bc);
        check("start_win_lo", {32'd0, lo}, 64'h91A);
        check("start_win_hi", {32'd0, hi}, 64'd0);

        // Reset in the middle of a multiply
        issue(2'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_hi", {32'd0, hi}, 64'd0);
        check("arst_lo", {32'd0, lo}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("arst_no_done", 64'(ndone), 64'd0);
        run_op("fresh", 2'd0, 32'd7, 32'hFFFF_FFFD, MUL_LAT + 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

        repeat (2) @(posedge clk);
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a new operation, sampled at a rising edge.
REQ-005 SHALL have port: op  input  2  operation: 0 mult, 1 multu, 2 div, 3 divu.
REQ-006 SHALL have port: src_a  input  32  RS operand (multiplicand / dividend).
REQ-007 SHALL have port: src_b  input  32  RT operand (multiplier / divisor).
REQ-008 SHALL have port: mthi / mtlo  input  1 each  write src_a into HI / LO.
REQ-009 SHALL have port: flush  input  1  abort the in-flight operation.
REQ-010 SHALL have port: busy  output  1  operation in flight; the pipeline stalls mfhi/mflo/mult/div on it.
REQ-011 SHALL have port: done  output  1  single-cycle pulse when HI/LO are committed.
REQ-012 SHALL have port: div_by_zero  output  1  single-cycle pulse with done on divide by zero.
REQ-013 SHALL have port: hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, FIX.
REQ-015 SHALL accept start only in IDLE, and SHALL ignore start while busy.
- On acceptance, src_a, src_b and op SHALL be latched.
- op 0/1 SHALL go to MUL, op 2/3 SHALL go to DIV.
REQ-016 SHALL drive busy=1 in every state other than IDLE, with busy rising at the accepting edge.
REQ-017 div/divu SHALL use restoring radix-2 division on magnitudes for 32 DIV cycles, then 1 FIX cycle that applies signs and writes HI/LO.
- done SHALL be high in the cycle after FIX.
- Total: HI/LO are valid 33 edges after the accepting edge.
REQ-018 Signed division SHALL give lo = quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-019 div with 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, with no error flag.
REQ-020 A divisor of 0 SHALL skip DIV and go straight to FIX.
- HI/LO SHALL remain unchanged.
- done and div_by_zero SHALL pulse together 2 edges after acceptance.
REQ-021 mult SHALL compute the signed 64-bit product and multu the unsigned 64-bit product; {hi,lo} SHALL receive the product at FIX.
REQ-022 mthi/mtlo SHALL write HI/LO at the edge only when in IDLE, not flushing, and with start low; otherwise they are ignored.
- mthi and mtlo asserted together SHALL write both registers.
REQ-023 flush SHALL return the FSM to IDLE at the next edge from any state.
- HI/LO SHALL remain unchanged and done SHALL NOT pulse.
- flush SHALL take priority over start and over FIX commit in the same cycle.
REQ-024 A new start SHALL be accepted in the first IDLE cycle, i.e. the cycle in which done is high.
REQ-025 done and div_by_zero SHALL be registered outputs; hi and lo SHALL be direct register outputs.

Reset
REQ-026 rst_n low SHALL asynchronously force:
- state=IDLE, busy=0, done=0, div_by_zero=0;
- hi=0, lo=0, all latched operands and iteration counter = 0.
REQ-027 Reset asserted mid-operation SHALL discard the operation with no done pulse.
- The first start after deassertion SHALL behave as a fresh operation.

Configuration
REQ-028 Macro MULDIV_FAST_MULT_EN SHALL select multiply latency.
- Defined: MUL lasts 1 cycle using a single-cycle 64-bit multiplier; done 3 edges after acceptance.
- Undefined: MUL performs 32-cycle shift-add on magnitudes with sign fix in FIX; done 34 edges after acceptance.
- Division behaviour SHALL be identical in both builds.

Verification
REQ-029 SHALL cover: div: src_a=-7 (0xFFFFFFF9), src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done 34 edges after start, busy high for 33 cycles.
REQ-030 SHALL cover: divu: src_a=0xFFFFFFFF, src_b=0x10 -> lo=0x0FFFFFFF, hi=0xF; then div by 0 -> HI/LO unchanged, done and div_by_zero pulse 2 edges after start.
REQ-031 SHALL cover: mult: 0xFFFFFFFF x 2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=0x1, lo=0xFFFFFFFE; check latency in both macro builds.
REQ-032 SHALL cover: flush at DIV cycle 10 -> busy=0 next cycle, no done, HI/LO keep prior values; start in that idle cycle is accepted.
REQ-033 SHALL cover: mthi with src_a=0x1234 while busy -> ignored; mthi in IDLE -> hi=0x1234; start and mtlo in the same idle cycle -> start wins, mtlo dropped.
REQ-034 SHALL cover: rst_n pulsed low mid-MUL -> all outputs 0 immediately, no done pulse after release.
